pipeline_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage core pipeline (IF, ID, EX, MEM, WB). It drives the per-register stall/flush pair of the four inter-stage pipeline registers (0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB) and the PC hold. It resolves memory waits, multi-cycle EX, control-flow redirects, load-use hazards and serialising instructions, and keeps a stall performance counter. Flush overrides stall inside each pipeline register; this block relies on that.

---
 rtl/pipeline_ctrl.sv | 109 ++++++++++
 tb/tb_pipeline_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: per-register stall/flush,
// PC hold, RUN/DRAIN sequencing for serialising instructions, and a stall cycle counter.
module pipeline_ctrl #(
    parameter int XLEN_CNT   = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  id_serialize,
    input  logic                  ex_valid,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_redirect,
    input  logic                  ex_busy,
    input  logic                  mem_wait,
    input  logic                  imem_ready,
    output logic                  pc_stall,
    output logic [3:0]            stall,
    output logic [3:0]            flush,
    output logic                  draining,
    output logic [XLEN_CNT-1:0]   stall_count
);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t      state, state_next;
    logic [3:1]  occ, occ_next;
    logic        load_use;
    logic        occ_empty;

    assign occ_empty = (occ == 3'b000);

    // x0 is hardwired to zero, so a load targeting it can never create a hazard.
    assign load_use = ex_valid && ex_is_load && (ex_rd != '0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    // NOTE: every output of this block gets a default first; a path that skips one would infer a latch.
    always_comb begin
        stall      = 4'b0000;
        flush      = 4'b0000;
        pc_stall   = 1'b0;
        state_next = state;
        if (reset) begin
            flush    = 4'b1111;
            pc_stall = 1'b1;
        end else if (mem_wait) begin
            stall    = 4'b1111;
            pc_stall = 1'b1;
        end else if (ex_busy) begin
            stall    = 4'b0011;
            flush    = 4'b0100;
            pc_stall = 1'b1;
        end else if (ex_redirect) begin
            flush      = 4'b0011;
            state_next = RUN;
        end else if (load_use) begin
            stall    = 4'b0001;
            flush    = 4'b0010;
            pc_stall = 1'b1;
        end else if (((state == RUN) && id_valid && id_serialize && !occ_empty) ||
                     ((state == DRAIN) && !occ_empty)) begin
            // Hold the serialising instruction in ID and inject bubbles until EX/MEM/WB empty.
            stall      = 4'b0001;
            flush      = 4'b0010;
            pc_stall   = 1'b1;
            state_next = DRAIN;
        end else begin
            state_next = RUN;
            if (!imem_ready) begin
                flush    = 4'b0001;
                pc_stall = 1'b1;
            end
        end
    end

    always_comb begin
        occ_next[1] = flush[1] ? 1'b0 : (stall[1] ? occ[1] : id_valid);
        occ_next[2] = flush[2] ? 1'b0 : (stall[2] ? occ[2] : occ[1]);
        occ_next[3] = flush[3] ? 1'b0 : (stall[3] ? occ[3] : occ[2]);
    end

    assign draining = (state == DRAIN) && !reset;

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            occ   <= 3'b000;
        end else begin
            state <= state_next;
            occ   <= occ_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (pc_stall) begin
            stall_count <= stall_count + XLEN_CNT'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl, built with a 4-bit stall counter
// so the wrap case is reachable in a handful of cycles.
module tb_pipeline_ctrl;

    localparam int XLEN_CNT   = 4;
    localparam int REG_ADDR_W = 5;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic                  id_serialize;
    logic                  ex_valid;
    logic                  ex_is_load;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_redirect;
    logic                  ex_busy;
    logic                  mem_wait;
    logic                  imem_ready;
    logic                  pc_stall;
    logic [3:0]            stall;
    logic [3:0]            flush;
    logic                  draining;
    logic [XLEN_CNT-1:0]   stall_count;

    int compared   = 0;
    int mismatched = 0;

    pipeline_ctrl #(.XLEN_CNT(XLEN_CNT), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_serialize (id_serialize),
        .ex_valid     (ex_valid),
        .ex_is_load   (ex_is_load),
        .ex_rd        (ex_rd),
        .ex_redirect  (ex_redirect),
        .ex_busy      (ex_busy),
        .mem_wait     (mem_wait),
        .imem_ready   (imem_ready),
        .pc_stall     (pc_stall),
        .stall        (stall),
        .flush        (flush),
        .draining     (draining),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] e_stall,
                             input logic [3:0] e_flush, input logic e_pc);
        check({tag, ".stall"},    32'(stall),    32'(e_stall));
        check({tag, ".flush"},    32'(flush),    32'(e_flush));
        check({tag, ".pc_stall"}, 32'(pc_stall), 32'(e_pc));
    endtask

    task automatic idle();
        id_valid     = 1'b0;
        id_rs1       = '0;
        id_rs2       = '0;
        id_uses_rs1  = 1'b0;
        id_uses_rs2  = 1'b0;
        id_serialize = 1'b0;
        ex_valid     = 1'b0;
        ex_is_load   = 1'b0;
        ex_rd        = '0;
        ex_redirect  = 1'b0;
        ex_busy      = 1'b0;
        mem_wait     = 1'b0;
        imem_ready   = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        idle();
        #1;
        check_out("reset", 4'b0000, 4'b1111, 1'b1);
        check("reset.draining", 32'(draining), 32'd0);
        check("reset.count", 32'(stall_count), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check_out("idle", 4'b0000, 4'b0000, 1'b0);

        // Load-use on rs2: one bubble, then clear
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
        id_valid = 1'b1; id_uses_rs2 = 1'b1; id_rs2 = 5'd5;
        #1;
        check_out("load_use", 4'b0001, 4'b0010, 1'b1);
        tick();
        ex_is_load = 1'b0;
        #1;
        check_out("load_use_next", 4'b0000, 4'b0000, 1'b0);
        check("load_use.count", 32'(stall_count), 32'd1);

        // Load to x0 never hazards
        ex_is_load = 1'b1; ex_rd = 5'd0; id_uses_rs1 = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0;
        #1;
        check_out("x0_load", 4'b0000, 4'b0000, 1'b0);
        tick();

        // Redirect beats load-use
        ex_rd = 5'd7; id_rs1 = 5'd7; ex_redirect = 1'b1;
        #1;
        check_out("redirect_lu", 4'b0000, 4'b0011, 1'b0);
        tick();
        check("redirect.count", 32'(stall_count), 32'd1);

        // mem_wait for 3 cycles defers redirect
        idle();
        ex_redirect = 1'b1; mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_out($sformatf("mem_wait%0d", i), 4'b1111, 4'b0000, 1'b1);
            tick();
        end
        mem_wait = 1'b0;
        #1;
        check_out("mem_wait_redirect", 4'b0000, 4'b0011, 1'b0);
        tick();
        check("mem_wait.count", 32'(stall_count), 32'd4);

        // Multi-cycle EX and fetch miss
        idle();
        ex_busy = 1'b1;
        #1;
        check_out("ex_busy", 4'b0011, 4'b0100, 1'b1);
        tick();
        idle();
        imem_ready = 1'b0;
        #1;
        check_out("imem_miss", 4'b0000, 4'b0001, 1'b1);
        tick();
        check("imem.count", 32'(stall_count), 32'd6);

        // Serialise with full pipeline: 3 holds, release on the 4th cycle
        idle();
        reset = 1'b1;
        #1;
        check("async_reset.count", 32'(stall_count), 32'd0);
        reset = 1'b0;
        id_valid = 1'b1;
        tick(); tick(); tick();
        id_serialize = 1'b1;
        #1;
        check_out("ser_hold0", 4'b0001, 4'b0010, 1'b1);
        check("ser_hold0.draining", 32'(draining), 32'd0);
        tick();
        for (int i = 1; i < 3; i++) begin
            check_out($sformatf("ser_hold%0d", i), 4'b0001, 4'b0010, 1'b1);
            check($sformatf("ser_hold%0d.draining", i), 32'(draining), 32'd1);
            tick();
        end
        check_out("ser_release", 4'b0000, 4'b0000, 1'b0);
        check("ser_release.draining", 32'(draining), 32'd1);
        tick();
        id_serialize = 1'b0;
        #1;
        check("ser_after.draining", 32'(draining), 32'd0);
        check("ser.count", 32'(stall_count), 32'd3);

        // DRAIN interrupted by redirect
        id_serialize = 1'b1;
        #1;
        check_out("drain2_enter", 4'b0001, 4'b0010, 1'b1);
        tick();
        check("drain2.draining", 32'(draining), 32'd1);
        ex_redirect = 1'b1;
        #1;
        check_out("drain_redirect", 4'b0000, 4'b0011, 1'b0);
        tick();
        ex_redirect = 1'b0; id_serialize = 1'b0;
        #1;
        check("drain_redirect.draining", 32'(draining), 32'd0);

        // DRAIN held by mem_wait, then reset mid-DRAIN
        tick();
        id_serialize = 1'b1;
        #1;
        check_out("drain3_enter", 4'b0001, 4'b0010, 1'b1);
        tick();
        mem_wait = 1'b1;
        #1;
        check_out("drain_mem_wait", 4'b1111, 4'b0000, 1'b1);
        tick();
        check("drain_mem_wait.draining", 32'(draining), 32'd1);
        reset = 1'b1;
        #1;
        check_out("mid_drain_reset", 4'b0000, 4'b1111, 1'b1);
        check("mid_drain_reset.draining", 32'(draining), 32'd0);
        check("mid_drain_reset.count", 32'(stall_count), 32'd0);
        idle();
        reset = 1'b0;
        #1;

        // Counter wrap at 4 bits
        imem_ready = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("count_all_ones", 32'(stall_count), 32'd15);
        tick();
        check("count_wrap", 32'(stall_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
